// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode encodings, ALUOp codes and the
// packed control bundle carried from ID into the ID/EX pipeline register.
package rv_pkg;

  // Base opcodes (instruction bits [6:0]) handled by this datapath.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // All-zero opcode is the pipeline bubble, not an illegal instruction.
  localparam logic [6:0] OP_BUBBLE = 7'b0000000;

  // ALU operation class handed to the ALU control stage.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Control bundle; field order matches ex_ctrl[7:0] MSB first.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode -> control bundle decoder. Any opcode that
// does not exactly match a supported encoding (including X/Z bits, which
// never match a case item) falls into the default NOP bundle.
module ctrl_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal_op,
  output logic       is_bubble
);

  // Main decode table; unlisted fields stay 0 from the defaults.
  always_comb begin
    ctrl       = CTRL_NOP;
    illegal_op = 1'b0;
    is_bubble  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LOAD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_BUBBLE: begin
        is_bubble = 1'b1;
      end
      default: begin
        illegal_op = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I main control unit: combinational decode for the ID stage, a
// registered copy of the bundle for the ID/EX register (rst > flush >
// stall > load), and sticky/saturating illegal-opcode bookkeeping.
//
// Valid semantics: in_valid qualifies opcode as a real instruction in ID.
// ex_valid marks the ID/EX slot as holding a legal, non-bubble instruction;
// it follows the same hold/flush rules as ex_ctrl. There is no ready
// back-pressure path: stall is the only hold mechanism.
module control_unit
  import rv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             Branch,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [1:0]       ALUOp,
  output logic             illegal_op,
  output logic [7:0]       ex_ctrl,
  output logic             ex_valid,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] illegal_count
);

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             dec_bubble;
  ctrl_t            ex_ctrl_q;
  logic             ex_valid_q;
  logic             seen_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_en;
  logic             count_en;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .ctrl       (dec_ctrl),
    .illegal_op (dec_illegal),
    .is_bubble  (dec_bubble)
  );

  // Expose the decoded bundle on the individual combinational outputs.
  always_comb begin
    MemRead    = dec_ctrl.mem_read;
    MemWrite   = dec_ctrl.mem_write;
    MemToReg   = dec_ctrl.mem_to_reg;
    Branch     = dec_ctrl.branch;
    ALUSrc     = dec_ctrl.alu_src;
    RegWrite   = dec_ctrl.reg_write;
    ALUOp      = dec_ctrl.alu_op;
    illegal_op = dec_illegal;
  end

  // A load cycle is one where neither flush nor stall holds the slot;
  // illegal bookkeeping only counts real illegal instructions on such cycles.
  always_comb begin
    load_en  = ~flush & ~stall;
    count_en = load_en & in_valid & dec_illegal;
  end

  // ID/EX control register with flush winning over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= CTRL_NOP;
      ex_valid_q <= 1'b0;
    end else if (flush) begin
      ex_ctrl_q  <= CTRL_NOP;
      ex_valid_q <= 1'b0;
    end else if (load_en) begin
      ex_ctrl_q  <= dec_ctrl;
      ex_valid_q <= in_valid & ~dec_illegal & ~dec_bubble;
    end
  end

  // Sticky illegal flag and saturating counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else if (count_en) begin
      seen_q <= 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Drive registered outputs.
  always_comb begin
    ex_ctrl       = ex_ctrl_q;
    ex_valid      = ex_valid_q;
    illegal_seen  = seen_q;
    illegal_count = cnt_q;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;

  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  logic [6:0]       opcode   = '0;
  logic             in_valid = 1'b0;
  logic             stall    = 1'b0;
  logic             flush    = 1'b0;
  logic             MemRead, MemWrite, MemToReg, Branch, ALUSrc, RegWrite;
  logic [1:0]       ALUOp;
  logic             illegal_op;
  logic [7:0]       ex_ctrl;
  logic             ex_valid;
  logic             illegal_seen;
  logic [CNT_W-1:0] illegal_count;

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemToReg      (MemToReg),
    .Branch        (Branch),
    .ALUSrc        (ALUSrc),
    .RegWrite      (RegWrite),
    .ALUOp         (ALUOp),
    .illegal_op    (illegal_op),
    .ex_ctrl       (ex_ctrl),
    .ex_valid      (ex_valid),
    .illegal_seen  (illegal_seen),
    .illegal_count (illegal_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] comb_bundle();
    return {MemRead, MemWrite, MemToReg, Branch, ALUSrc, RegWrite, ALUOp};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic v, input logic s, input logic f);
    opcode   = op;
    in_valid = v;
    stall    = s;
    flush    = f;
  endtask

  // Hand-computed decode table {MemRead,MemWrite,MemToReg,Branch,ALUSrc,RegWrite,ALUOp}
  logic [6:0] tbl_op  [6] = '{7'b0000000, 7'b0110011, 7'b0010011,
                              7'b0000011, 7'b0100011, 7'b1100011};
  logic [7:0] tbl_exp [6] = '{8'b0000_0000, 8'b0000_0110, 8'b0000_1110,
                              8'b1010_1100, 8'b0100_1000, 8'b0001_0001};
  logic [7:0] exp_q[$];

  initial begin
    // ---- combinational walk, clock not running ----
    for (int i = 0; i < 6; i++) begin
      opcode = tbl_op[i];
      #1;
      check_eq($sformatf("decode_%b", tbl_op[i]), comb_bundle(), tbl_exp[i]);
      check_eq($sformatf("illegal_%b", tbl_op[i]), illegal_op, 1'b0);
    end
    opcode = 7'b1111111;
    #1;
    check_eq("decode_1111111", comb_bundle(), 8'h00);
    check_eq("illegal_1111111", illegal_op, 1'b1);
    opcode = 7'bxxxxxxx;
    #1;
    check_eq("decode_x", comb_bundle(), 8'h00);

    // ---- reset ----
    clk_en = 1'b1;
    drive(7'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_ex_ctrl", ex_ctrl, 8'h00);
    check_eq("rst_ex_valid", ex_valid, 1'b0);
    check_eq("rst_seen", illegal_seen, 1'b0);
    check_eq("rst_count", illegal_count, 0);

    // ---- load / stall / flush ----
    drive(7'b0100011, 1'b1, 1'b0, 1'b0);
    tick();
    exp_q.push_back(8'b0100_1000);
    check_eq("load_store_ctrl", ex_ctrl, exp_q.pop_front());
    check_eq("load_store_valid", ex_valid, 1'b1);

    drive(7'b1100011, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("stall_hold_ctrl", ex_ctrl, 8'b0100_1000);
    check_eq("stall_hold_valid", ex_valid, 1'b1);

    drive(7'b1100011, 1'b1, 1'b1, 1'b1);
    tick();
    check_eq("flush_stall_ctrl", ex_ctrl, 8'h00);
    check_eq("flush_stall_valid", ex_valid, 1'b0);

    drive(7'b1100011, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("load_branch_ctrl", ex_ctrl, 8'b0001_0001);
    check_eq("load_branch_valid", ex_valid, 1'b1);

    drive(7'b0110011, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("no_valid_ctrl", ex_ctrl, 8'b0000_0110);
    check_eq("no_valid_valid", ex_valid, 1'b0);

    drive(7'b0000000, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("bubble_ctrl", ex_ctrl, 8'h00);
    check_eq("bubble_valid", ex_valid, 1'b0);
    check_eq("bubble_count", illegal_count, 0);

    // ---- illegal bookkeeping gating ----
    drive(7'b1111111, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("ill_novalid_count", illegal_count, 0);
    drive(7'b1111111, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("ill_stall_count", illegal_count, 0);
    drive(7'b1111111, 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("ill_flush_count", illegal_count, 0);
    check_eq("ill_flush_seen", illegal_seen, 1'b0);

    drive(7'b1111111, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("ill_first_count", illegal_count, 1);
    check_eq("ill_first_seen", illegal_seen, 1'b1);
    check_eq("ill_first_valid", ex_valid, 1'b0);
    check_eq("ill_first_ctrl", ex_ctrl, 8'h00);

    for (int i = 1; i < 254; i++) tick();
    check_eq("ill_254_count", illegal_count, 254);
    tick();
    check_eq("ill_255_count", illegal_count, 255);
    for (int i = 255; i < 300; i++) tick();
    check_eq("ill_sat_count", illegal_count, 255);
    check_eq("ill_sat_seen", illegal_seen, 1'b1);

    // Seen flag stays set on legal cycles.
    drive(7'b0110011, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("seen_sticky", illegal_seen, 1'b1);
    check_eq("count_hold", illegal_count, 255);

    // ---- mid-run reset ----
    drive(7'b1111111, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("rst_comb_illegal", illegal_op, 1'b1);
    tick();
    rst = 1'b0;
    check_eq("rst2_count", illegal_count, 0);
    check_eq("rst2_seen", illegal_seen, 1'b0);
    check_eq("rst2_ctrl", ex_ctrl, 8'h00);
    check_eq("rst2_valid", ex_valid, 1'b0);
    drive(7'b0000011, 1'b0, 1'b0, 1'b0);

    // ---- opcode sweep ----
    begin
      int n_ill;
      int n_bad_bundle;
      n_ill = 0;
      n_bad_bundle = 0;
      for (int i = 0; i < 128; i++) begin
        opcode = 7'(i);
        #1;
        if (illegal_op) begin
          n_ill++;
          if (comb_bundle() != 8'h00) n_bad_bundle++;
        end
      end
      check_eq("sweep_illegal_total", n_ill, 122);
      check_eq("sweep_illegal_bundle", n_bad_bundle, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Main decoder for the single-issue RV32I datapath: maps the 7-bit instruction opcode to the datapath control bundle (memory, branch, ALU-source, write-back, ALUOp). The decode path is purely combinational and feeds the ID stage directly. A registered copy of the bundle, with stall/flush, drives the ID/EX pipeline register. Illegal-opcode bookkeeping is also registered here.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - `CNT_W`, default 8: width of the saturating illegal-opcode counter.
- Ports:
  - `clk`, in, 1: rising-edge clock.
  - `rst`, in, 1: synchronous active-high reset.
  - `opcode`, in, 7: instruction bits [6:0].
  - `in_valid`, in, 1: the ID stage holds a real instruction.
  - `stall`, in, 1: hold the ID/EX bundle.
  - `flush`, in, 1: bubble the ID/EX bundle.
  - `MemRead`, out, 1: combinational; data-memory read.
  - `MemWrite`, out, 1: combinational; data-memory write.
  - `MemToReg`, out, 1: combinational; write-back selects memory data.
  - `Branch`, out, 1: combinational; conditional branch.
  - `ALUSrc`, out, 1: combinational; ALU operand B is the immediate.
  - `RegWrite`, out, 1: combinational; register-file write.
  - `ALUOp`, out, 2: combinational; 00 = add (address), 01 = subtract/compare, 10 = decode funct fields.
  - `illegal_op`, out, 1: combinational; opcode unsupported.
  - `ex_ctrl`, out, 8: registered bundle {MemRead, MemWrite, MemToReg, Branch, ALUSrc, RegWrite, ALUOp[1:0]}.
  - `ex_valid`, out, 1: registered; the ID/EX slot holds a legal instruction.
  - `illegal_seen`, out, 1: registered sticky flag.
  - `illegal_count`, out, CNT_W: registered saturating count of illegal opcodes.

## Operation
Decode table (all unlisted signals 0):
- 0110011 R-type: RegWrite=1, ALUOp=10.
- 0010011 I-ALU: ALUSrc=1, RegWrite=1, ALUOp=10.
- 0000011 load: MemRead=1, MemToReg=1, ALUSrc=1, RegWrite=1, ALUOp=00.
- 0100011 store: MemWrite=1, ALUSrc=1, ALUOp=00.
- 1100011 branch: Branch=1, ALUOp=01.
- Any other opcode: every control output 0 and ALUOp=00 (NOP behaviour).

Rules:
- X/Z bits in `opcode` are treated as unsupported: the bundle is 0 and the outputs are never X.
- `illegal_op` = 1 for any opcode outside the five listed, except 0000000, which is the bubble encoding and gives `illegal_op` = 0.
- The combinational outputs depend only on `opcode`. They ignore `clk`, `rst`, `in_valid`, `stall` and `flush`.

## Timing
- Combinational outputs settle within the same cycle; no clock is needed.
- Registered outputs update on the rising `clk` edge. Priority is `rst` > `flush` > `stall` > load.
  - `rst`: `ex_ctrl`=0, `ex_valid`=0, `illegal_seen`=0, `illegal_count`=0.
  - `flush`: `ex_ctrl`=0, `ex_valid`=0. A flush overrides a simultaneous stall.
  - `stall` (no flush): `ex_ctrl` and `ex_valid` hold their values.
  - Load: `ex_ctrl` ← current decode bundle; `ex_valid` ← `in_valid` & ~`illegal_op` & (`opcode`≠0).
- Latency is 1 cycle from `opcode` to `ex_ctrl`.
- Illegal bookkeeping applies only on a load cycle (no rst, no flush, no stall) with `in_valid`=1 and `illegal_op`=1.
  - On such a cycle, `illegal_seen` ← 1 and `illegal_count` increments by 1.
  - `illegal_count` saturates at 2^CNT_W−1 and never wraps.
  - `illegal_seen` clears only on `rst`.
- Asserting `rst` mid-operation clears all registered state on that edge. The combinational outputs are unaffected.

## Structure
- Shared package `rv_pkg` holds:
  - Opcode constants: OP_R=0110011, OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - The packed `ctrl_t` bundle typedef, in the bit order of `ex_ctrl`.
- One sub-module is natural: `ctrl_decode`, a purely combinational opcode→`ctrl_t` decoder plus `illegal_op`. The top level adds the ID/EX register and the illegal-opcode counter.

## Test plan
- Walk all five opcodes plus 0000000, holding each value for 1 ns with no clock running; the combinational outputs must match the decode table.
  - For 0000000, the expected outputs are all 0 and ALUOp=00.
  - For 0110011, the expected outputs are RegWrite=1, ALUOp=10 and all others 0.
  - For 0000011, the expected outputs are MemRead=1, MemToReg=1, ALUSrc=1, RegWrite=1, ALUOp=00.
- Apply unsupported opcode 1111111, then X on `opcode` → all control outputs 0. `illegal_op`=1 for 1111111.
- Apply `rst`=1 for one edge, then load 0100011 with `in_valid`=1 → next edge `ex_ctrl`=01001000 and `ex_valid`=1.
- Present 1100011 with `stall`=1 → `ex_ctrl` holds. Assert `flush` and `stall` together → `ex_ctrl`=0 and `ex_valid`=0.
- Drive 1111111 with `in_valid`=1 for 300 load cycles with CNT_W=8 → `illegal_count`=255 and `illegal_seen`=1. Then `rst` → both read 0.
- Sweep all 128 opcodes → `illegal_op` is set exactly for the 122 encodings outside the five listed and 0000000.
